// File: rtl/key_onehot_capture_pkg.sv
// Shared width, FSM state type and one-hot helpers for the key capture front end.
package key_pkg;

  localparam int KEY_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Later (higher) indices overwrite earlier ones, leaving only the top set bit.
  function automatic logic [KEY_W-1:0] msb_isolate(input logic [KEY_W-1:0] v);
    logic [KEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_onehot_capture_if.sv
// Key lines in, captured one-hot code plus valid/error strobes out.
interface key_if
  import key_pkg::*;
();
  logic [KEY_W-1:0] iKey;
  logic [KEY_W-1:0] oData;
  logic             oValid;
  logic             oErr;

  modport slave  (input  iKey, output oData, output oValid, output oErr);
  modport master (output iKey, input  oData, input  oValid, input  oErr);
endinterface

// File: rtl/key_onehot_capture_debounce.sv
// One key line: 2-FF synchroniser followed by a saturating-compare debounce counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic key_i,
  output logic stable_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/key_onehot_capture.sv
// Debounced single-press capture feeding an 8-to-3 encoder with clean one-hot codes.
// KEY_MULTI_PRIORITY_EN: multi-key press captures the highest key instead of flagging oErr.
module key_onehot_capture
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic  iClk,
  input  logic  iRst_n,
  key_if.slave  bus
);
  logic [KEY_W-1:0] stable;
  key_state_t       state_q, state_d;
  logic [KEY_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  for (genvar g = 0; g < KEY_W; g++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .key_i    (bus.iKey[g]),
      .stable_o (stable[g])
    );
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable != '0) begin
          state_d = HELD;
          if (is_onehot(stable)) begin
            data_d  = stable;
            valid_d = 1'b1;
          end else begin
`ifdef KEY_MULTI_PRIORITY_EN
            data_d  = msb_isolate(stable);
            valid_d = 1'b1;
`else
            err_d   = 1'b1;
`endif
          end
        end
      end
      HELD: begin
        // Outputs frozen until every key is released.
        if (stable == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;
  assign bus.oErr   = err_q;
endmodule
